// File: rtl/pipe_mem.sv
// rtl/pipe_mem.sv - MEM pipeline stage driving a request/response data SRAM port
module pipe_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        from_valid,
  input  logic        from_allowin,
  input  logic [31:0] from_pc,
  input  logic [31:0] alu_result_EX,
  input  logic        rf_we_EX,
  input  logic [4:0]  rf_waddr_EX,
  input  logic        res_from_mem_EX,
  input  logic [4:0]  ld_op_EX,
  input  logic [2:0]  st_op_EX,
  input  logic [31:0] st_data_EX,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        to_valid,
  output logic        to_allowin,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        valid;
  logic [31:0] pc_r, alu_r, st_data_r, buf_r;
  logic        rf_we_r, res_from_mem_r;
  logic [4:0]  rf_waddr_r, ld_op_r;
  logic [2:0]  st_op_r;
  logic        ready_go, capture, is_mem_r, is_mem_in;
  logic [31:0] buf_shifted, load_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem_r  = (|ld_op_r) | (|st_op_r);
  assign is_mem_in = (|ld_op_EX) | (|st_op_EX);

  // A memory instruction may only leave once its response is in the buffer.
  assign ready_go   = is_mem_r ? (state == DONE) : valid;
  assign to_allowin = !valid | (ready_go & from_allowin);
  assign to_valid   = valid & ready_go;
  assign capture    = from_valid & to_allowin;

  // Stage valid bit: refilled whenever the stage may accept.
  always_ff @(posedge clk) begin
    if (reset)           valid <= 1'b0;
    else if (to_allowin) valid <= from_valid;
  end

  // Instruction bundle registers, loaded only on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r           <= '0;
      alu_r          <= '0;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= '0;
      res_from_mem_r <= 1'b0;
      ld_op_r        <= '0;
      st_op_r        <= '0;
      st_data_r      <= '0;
    end else if (capture) begin
      pc_r           <= from_pc;
      alu_r          <= alu_result_EX;
      rf_we_r        <= rf_we_EX;
      rf_waddr_r     <= rf_waddr_EX;
      res_from_mem_r <= res_from_mem_EX;
      ld_op_r        <= ld_op_EX;
      st_op_r        <= st_op_EX;
      st_data_r      <= st_data_EX;
    end
  end

  // FSM state register and response buffer; data_ok only counts while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      buf_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && data_sram_data_ok) buf_r <= data_sram_rdata;
    end
  end

  // Next-state logic; a capture always restarts the sequence for the new instruction.
  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = is_mem_in ? REQ : IDLE;
    end else begin
      case (state)
        REQ:     if (data_sram_addr_ok) state_nxt = WAIT;
        WAIT:    if (data_sram_data_ok) state_nxt = DONE;
        DONE:    if (to_valid & from_allowin) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  assign data_sram_req  = valid & (state == REQ);
  assign data_sram_wr   = |st_op_r;
  assign data_sram_addr = alu_r;

  // Store byte lanes and replicated write data.
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = st_data_r;
    if (st_op_r[0]) begin
      data_sram_wstrb = 4'b0001 << alu_r[1:0];
      data_sram_wdata = {4{st_data_r[7:0]}};
    end else if (st_op_r[1]) begin
      data_sram_wstrb = alu_r[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{st_data_r[15:0]}};
    end else if (st_op_r[2]) begin
      data_sram_wstrb = 4'b1111;
    end
  end

  assign buf_shifted = buf_r >> {alu_r[1:0], 3'b000};
  assign ld_byte     = buf_shifted[7:0];
  assign ld_half     = alu_r[1] ? buf_r[31:16] : buf_r[15:0];

  // Load result selection with sign or zero extension.
  always_comb begin
    load_result = buf_r;
    if (ld_op_r[0])      load_result = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op_r[1]) load_result = {{16{ld_half[15]}}, ld_half};
    else if (ld_op_r[3]) load_result = {24'b0, ld_byte};
    else if (ld_op_r[4]) load_result = {16'b0, ld_half};
  end

  assign rf_we    = rf_we_r & valid;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = res_from_mem_r ? load_result : alu_r;
  assign PC       = pc_r;

endmodule

// File: tb/tb_pipe_mem.sv
// tb/tb_pipe_mem.sv - self-checking bench for pipe_mem with SRAM responder and model
module tb_pipe_mem;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        from_valid = 1'b0, from_allowin = 1'b1;
  logic [31:0] from_pc = '0, alu_result_EX = '0, st_data_EX = '0;
  logic        rf_we_EX = 1'b0, res_from_mem_EX = 1'b0;
  logic [4:0]  rf_waddr_EX = '0, ld_op_EX = '0;
  logic [2:0]  st_op_EX = '0;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        to_valid, to_allowin, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, PC;

  int n_tests = 0, n_fail = 0;
  int addr_delay = 0, data_delay = 1;
  logic [31:0] resp_rdata = '0;
  logic manual_data_ok = 1'b0;

  pipe_mem dut (
    .clk(clk), .reset(reset), .from_valid(from_valid), .from_allowin(from_allowin),
    .from_pc(from_pc), .alu_result_EX(alu_result_EX), .rf_we_EX(rf_we_EX),
    .rf_waddr_EX(rf_waddr_EX), .res_from_mem_EX(res_from_mem_EX), .ld_op_EX(ld_op_EX),
    .st_op_EX(st_op_EX), .st_data_EX(st_data_EX), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .to_valid(to_valid), .to_allowin(to_allowin),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .PC(PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics in plain arithmetic.
  function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * addr[1:0])) & 32'hFF;
    h = ((addr[1:0] >= 2) ? (d >> 16) : d) & 32'hFFFF;
    case (op)
      5'b00001: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      5'b00010: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      5'b01000: return b;
      5'b10000: return h;
      default:  return d;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [31:0] addr);
    case (op)
      3'b001:  return 4'(1 << addr[1:0]);
      3'b010:  return (addr[1:0] >= 2) ? 4'd12 : 4'd3;
      3'b100:  return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b001:  return (d & 32'hFF) * 32'h0101_0101;
      3'b010:  return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Model of the held instruction plus SRAM responder; checks every cycle on the falling edge.
  initial begin : compare
    logic m_valid, m_mem, m_acc, m_got, m_we, m_rfm;
    logic [31:0] m_pc, m_alu, m_sd, m_rdata;
    logic [4:0] m_wa, m_ld;
    logic [2:0] m_st;
    logic exp_ready, exp_allow, exp_req, pend;
    int req_cnt, wait_cnt;
    m_valid = 0; m_mem = 0; m_acc = 0; m_got = 0; m_we = 0; m_rfm = 0;
    m_pc = 0; m_alu = 0; m_sd = 0; m_rdata = 0; m_wa = 0; m_ld = 0; m_st = 0;
    pend = 0; req_cnt = 0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      exp_ready = m_valid && (!m_mem || m_got);
      exp_allow = !m_valid || (exp_ready && from_allowin);
      exp_req   = m_valid && m_mem && !m_acc;
      if (!reset) begin
        check("to_valid", to_valid, exp_ready);
        check("to_allowin", to_allowin, exp_allow);
        check("sram_req", data_sram_req, exp_req);
        check("rf_we", rf_we, m_valid && m_we);
        check("one_outstanding", pend && data_sram_req, 0);
        if (exp_req) begin
          check("sram_addr", data_sram_addr, m_alu);
          check("sram_wr", data_sram_wr, m_st != 0);
          check("sram_wstrb", data_sram_wstrb, model_strb(m_st, m_alu));
          if (m_st != 0) check("sram_wdata", data_sram_wdata, model_wdata(m_st, m_sd));
        end
        if (exp_ready) begin
          check("rf_wdata", rf_wdata, m_rfm ? model_load(m_ld, m_alu, m_rdata) : m_alu);
          check("rf_waddr", rf_waddr, m_wa);
          check("pc", PC, m_pc);
        end
      end
      data_sram_addr_ok = 0;
      data_sram_data_ok = 0;
      data_sram_rdata   = $urandom;
      if (reset) begin
        pend = 0; req_cnt = 0;
      end else if (pend) begin
        if (wait_cnt == 0) begin
          data_sram_data_ok = 1; data_sram_rdata = resp_rdata; pend = 0;
        end else wait_cnt--;
      end else if (data_sram_req) begin
        if (req_cnt >= addr_delay) begin
          data_sram_addr_ok = 1; pend = 1; wait_cnt = data_delay - 1; req_cnt = 0;
        end else req_cnt++;
      end
      if (manual_data_ok) begin
        data_sram_data_ok = 1; data_sram_rdata = resp_rdata;
      end
      if (reset) begin
        m_valid = 0; m_acc = 0; m_got = 0;
      end else begin
        if (m_valid && m_acc && !m_got && data_sram_data_ok) begin
          m_got = 1; m_rdata = data_sram_rdata;
        end
        if (exp_req && data_sram_addr_ok) m_acc = 1;
        if (from_valid && exp_allow) begin
          m_valid = 1; m_acc = 0; m_got = 0;
          m_pc = from_pc; m_alu = alu_result_EX; m_sd = st_data_EX;
          m_we = rf_we_EX; m_wa = rf_waddr_EX; m_rfm = res_from_mem_EX;
          m_ld = ld_op_EX; m_st = st_op_EX; m_mem = (ld_op_EX != 0) || (st_op_EX != 0);
        end else if (exp_ready && from_allowin) begin
          m_valid = 0;
        end
      end
    end
  end

  // Present one instruction and hold it until the stage accepts it.
  task automatic issue(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wa,
                       input logic we, input logic rfm);
    logic ok;
    from_valid = 1; ld_op_EX = ld; st_op_EX = st; from_pc = pc; alu_result_EX = alu;
    st_data_EX = sd; rf_waddr_EX = wa; rf_we_EX = we; res_from_mem_EX = rfm;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = to_allowin;
      @(posedge clk); #1;
    end
    from_valid = 0;
    check("issue_accepted", ok, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!to_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("to_valid_timeout", to_valid, 1);
  endtask

  typedef struct { logic [4:0] op; logic [31:0] addr, rdata, exp; } ld_vec_t;
  typedef struct { logic [2:0] op; logic [31:0] addr, data; logic [3:0] strb; logic [31:0] wdata; } st_vec_t;

  ld_vec_t lds[7] = '{
    '{5'b00001, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80},
    '{5'b01000, 32'h1003, 32'h80FF_0000, 32'h0000_0080},
    '{5'b00010, 32'h3002, 32'h8001_7F00, 32'hFFFF_8001},
    '{5'b10000, 32'h3000, 32'h8001_7F00, 32'h0000_7F00},
    '{5'b00010, 32'h3001, 32'h1234_F00D, 32'hFFFF_F00D},
    '{5'b00001, 32'h1001, 32'h0000_7F00, 32'h0000_007F},
    '{5'b00100, 32'h4002, 32'hCAFE_BABE, 32'hCAFE_BABE}
  };
  st_vec_t sts[5] = '{
    '{3'b010, 32'h2002, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF},
    '{3'b001, 32'h2001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5},
    '{3'b001, 32'h2003, 32'h1234_56C3, 4'b1000, 32'hC3C3_C3C3},
    '{3'b100, 32'h2003, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF},
    '{3'b010, 32'h2001, 32'h0000_1234, 4'b0011, 32'h1234_1234}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, cnt;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_to_valid", to_valid, 0);
    check("rst_req", data_sram_req, 0);
    check("rst_pc", PC, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_to_allowin", to_allowin, 1);

    // ALU instruction passes straight through.
    issue(5'b0, 3'b0, 32'h1C00_0000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
    check("alu_to_valid", to_valid, 1);
    check("alu_rf_wdata", rf_wdata, 32'h1234);
    check("alu_rf_waddr", rf_waddr, 5);
    check("alu_no_req", data_sram_req, 0);
    @(posedge clk); #1;

    // Loads with fixed one-cycle response latency.
    foreach (lds[i]) begin
      resp_rdata = lds[i].rdata;
      issue(lds[i].op, 3'b0, 32'h1C00_0100 + 4 * i, lds[i].addr, 32'h0, 5'd7, 1'b1, 1'b1);
      check("ld_req_first", data_sram_req, 1);
      wait_valid(lat);
      check("ld_latency", lat, 2);
      check("ld_rf_wdata", rf_wdata, lds[i].exp);
      @(posedge clk); #1;
    end

    // Stores; the first waits two extra cycles for addr_ok.
    foreach (sts[i]) begin
      addr_delay = (i == 0) ? 2 : 0;
      issue(3'b0 == 3'b1 ? 5'b0 : 5'b0, sts[i].op, 32'h1C00_0200 + 4 * i, sts[i].addr, sts[i].data, 5'd0, 1'b0, 1'b0);
      check("st_wr", data_sram_wr, 1);
      check("st_wstrb", data_sram_wstrb, sts[i].strb);
      check("st_wdata", data_sram_wdata, sts[i].wdata);
      cnt = 0;
      while (data_sram_req && cnt < 50) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("st_req_cycles", cnt, (i == 0) ? 3 : 1);
      wait_valid(lat);
      @(posedge clk); #1;
    end
    addr_delay = 0;

    // Back-pressure while DONE.
    from_allowin = 0;
    resp_rdata = 32'h1234_5678;
    issue(5'b00100, 3'b0, 32'h1C00_0300, 32'h6000, 32'h0, 5'd9, 1'b1, 1'b1);
    wait_valid(lat);
    for (int k = 0; k < 4; k++) begin
      check("bp_to_valid", to_valid, 1);
      check("bp_to_allowin", to_allowin, 0);
      check("bp_rf_wdata", rf_wdata, 32'h1234_5678);
      @(posedge clk); #1;
    end
    from_allowin = 1;
    #1;
    check("bp_release_allowin", to_allowin, 1);
    @(posedge clk); #1;
    check("bp_single_handover", to_valid, 0);

    // Back-to-back load then store.
    resp_rdata = 32'h0BAD_F00D;
    issue(5'b00100, 3'b0, 32'h1C00_0400, 32'h7000, 32'h0, 5'd3, 1'b1, 1'b1);
    issue(5'b0, 3'b100, 32'h1C00_0404, 32'h7004, 32'h5555_AAAA, 5'd0, 1'b0, 1'b0);
    check("b2b_second_req", data_sram_req, 1);
    check("b2b_second_addr", data_sram_addr, 32'h7004);
    wait_valid(lat);
    @(posedge clk); #1;

    // Reset while waiting for data; a late data_ok must be ignored.
    data_delay = 5;
    resp_rdata = 32'hFFFF_FFFF;
    issue(5'b00100, 3'b0, 32'h1C00_0500, 32'h8000, 32'h0, 5'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("rw_in_wait", data_sram_req, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    manual_data_ok = 1;
    @(posedge clk); #1;
    manual_data_ok = 0;
    check("rw_to_valid", to_valid, 0);
    check("rw_req", data_sram_req, 0);
    check("rw_pc", PC, 0);
    check("rw_rf_wdata", rf_wdata, 0);
    check("rw_rf_we", rf_we, 0);
    @(posedge clk); #1;
    check("rw_to_valid_later", to_valid, 0);
    data_delay = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
